// File: rtl/cb_bitop_seq_if.sv
// Bundle between the CB bit-op sequencer and the decoder, register file,
// (HL) memory port and ALU bit datapath.
interface cb_bitop_seq_if;
   logic       start;
   logic [7:0] opcode;
   logic       busy;
   logic       done;
   logic       illegal;

   logic [2:0] reg_rd_sel;
   logic [7:0] reg_rd_data;
   logic       reg_we;
   logic [2:0] reg_wr_sel;
   logic [7:0] reg_wr_data;

   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;

   logic [7:0] alu_a;
   logic [2:0] alu_b;
   logic [1:0] alu_fn;
   logic [7:0] alu_res;
   logic       alu_zf;

   logic       flag_we;
   logic       flag_z;
   logic       flag_n;
   logic       flag_h;

   // master: the sequencer; slave: decoder, register file, memory and ALU
   modport master (
      input  start, opcode, reg_rd_data, mem_rdata, mem_ack, alu_res, alu_zf,
      output busy, done, illegal, reg_rd_sel, reg_we, reg_wr_sel, reg_wr_data,
             mem_rd, mem_wr, mem_wdata, alu_a, alu_b, alu_fn,
             flag_we, flag_z, flag_n, flag_h
   );

   modport slave (
      output start, opcode, reg_rd_data, mem_rdata, mem_ack, alu_res, alu_zf,
      input  busy, done, illegal, reg_rd_sel, reg_we, reg_wr_sel, reg_wr_data,
             mem_rd, mem_wr, mem_wdata, alu_a, alu_b, alu_fn,
             flag_we, flag_z, flag_n, flag_h
   );
endinterface

// File: rtl/cb_bitop_seq.sv
// Sequencer for CB-prefixed BIT/RES/SET: feeds the ALU bit datapath and
// commits its result to a register, the (HL) byte, or Z/N/H.
module cb_bitop_seq (
   input  logic           clk,
   input  logic           reset,
   cb_bitop_seq_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EXEC  = 3'd1;
   localparam logic [2:0] S_MRD   = 3'd2;
   localparam logic [2:0] S_MEXEC = 3'd3;
   localparam logic [2:0] S_MWR   = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   localparam logic [1:0] OP_BIT  = 2'b01;
   localparam logic [2:0] REG_HL  = 3'd6;

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [7:0] opc_q;
   logic [7:0] temp_q;
   logic [7:0] wdata_q;
   logic       ill_q;

   logic [1:0] op;
   logic [2:0] bidx;
   logic [2:0] rsel;
   logic       is_bit;
   logic       in_exec;
   logic       in_mexec;
   logic       in_alu;

   assign op       = opc_q[7:6];
   assign bidx     = opc_q[5:3];
   assign rsel     = opc_q[2:0];
   assign is_bit   = (op == OP_BIT);
   assign in_exec  = (state == S_EXEC);
   assign in_mexec = (state == S_MEXEC);
   assign in_alu   = in_exec || in_mexec;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.opcode[7:6] == 2'b00)
                  state_nx = S_FIN;
               else if (bus.opcode[2:0] == REG_HL)
                  state_nx = S_MRD;
               else
                  state_nx = S_EXEC;
            end
         end
         S_EXEC:  state_nx = S_FIN;
         S_MRD:   if (bus.mem_ack) state_nx = S_MEXEC;
         S_MEXEC: state_nx = is_bit ? S_FIN : S_MWR;
         S_MWR:   if (bus.mem_ack) state_nx = S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         opc_q   <= 8'h00;
         temp_q  <= 8'h00;
         wdata_q <= 8'h00;
         ill_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && bus.start) begin
            opc_q <= bus.opcode;
            ill_q <= (bus.opcode[7:6] == 2'b00);
         end
         if (state == S_MRD && bus.mem_ack)
            temp_q <= bus.mem_rdata;
         // write data is frozen here so it stays stable for the whole MWR wait
         if (in_mexec && !is_bit)
            wdata_q <= bus.alu_res;
      end
   end

   // Outputs are forced low while reset is high so an abort never leaks a
   // strobe in the reset cycle itself.
   always_comb begin
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.mem_wdata  = 8'h00;
      bus.reg_rd_sel = 3'd0;
      if (!reset) begin
         bus.busy      = (state != S_IDLE) && (state != S_FIN);
         bus.done      = (state == S_FIN);
         bus.illegal   = (state == S_FIN) && ill_q;
         bus.mem_rd    = (state == S_MRD);
         bus.mem_wr    = (state == S_MWR);
         bus.mem_wdata = wdata_q;
         if (in_exec)
            bus.reg_rd_sel = rsel;
      end
   end

   always_comb begin
      bus.alu_a  = 8'h00;
      bus.alu_b  = 3'd0;
      bus.alu_fn = 2'b00;
      if (!reset && in_alu) begin
         bus.alu_a  = in_exec ? bus.reg_rd_data : temp_q;
         bus.alu_b  = bidx;
         bus.alu_fn = op;
      end
   end

   always_comb begin
      bus.flag_we     = 1'b0;
      bus.flag_z      = 1'b0;
      bus.flag_n      = 1'b0;
      bus.flag_h      = 1'b0;
      bus.reg_we      = 1'b0;
      bus.reg_wr_sel  = 3'd0;
      bus.reg_wr_data = 8'h00;
      if (!reset && in_alu) begin
         if (is_bit) begin
            bus.flag_we = 1'b1;
            bus.flag_z  = bus.alu_zf;
            bus.flag_h  = 1'b1;
         end else if (in_exec) begin
            bus.reg_we      = 1'b1;
            bus.reg_wr_sel  = rsel;
            bus.reg_wr_data = bus.alu_res;
         end
      end
   end

   a_mem_excl: assert property (@(posedge clk) disable iff (reset)
      !(bus.mem_rd && bus.mem_wr));
   a_done_not_busy: assert property (@(posedge clk) disable iff (reset)
      bus.done |-> !bus.busy);
   a_we_excl: assert property (@(posedge clk) disable iff (reset)
      !(bus.reg_we && bus.flag_we));

endmodule

// File: tb/tb_cb_bitop_seq.sv
// Bench for cb_bitop_seq: directed vectors, reset-abort sequence and random
// opcodes checked against an opcode-level reference model.
module tb_cb_bitop_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cb_bitop_seq_if bus();

   cb_bitop_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // environment: register file, the (HL) byte, ack generator and ALU
   logic [7:0] regs [8];
   logic [7:0] mem_hl;
   int         drd_cur;
   int         dwr_cur;
   int         wcnt;
   bit         noise_en;
   logic       tick = 1'b0;

   assign bus.reg_rd_data = regs[bus.reg_rd_sel];
   assign bus.mem_ack = (bus.mem_rd && wcnt == drd_cur) ||
                        (bus.mem_wr && wcnt == dwr_cur) ||
                        (!bus.mem_rd && !bus.mem_wr && noise_en && tick);
   assign bus.mem_rdata = (bus.mem_rd && bus.mem_ack) ? mem_hl : ~mem_hl;
   assign bus.alu_zf = ~bus.alu_a[bus.alu_b];

   always_comb begin
      case (bus.alu_fn)
         2'b10:   bus.alu_res = bus.alu_a & ~(8'h01 << bus.alu_b);
         2'b11:   bus.alu_res = bus.alu_a | (8'h01 << bus.alu_b);
         default: bus.alu_res = bus.alu_a;
      endcase
   end

   always @(posedge clk) begin
      tick <= ~tick;
      if (reset || !(bus.mem_rd || bus.mem_wr) || bus.mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   typedef struct {
      int         lat;
      bit         ill;
      int         regwe;
      logic [2:0] wsel;
      logic [7:0] wdata;
      int         flagwe;
      logic       fzv, fnv, fhv;
      int         rdcyc;
      int         wrcyc;
      logic [7:0] mdata;
      int         busycyc;
      int         alu_act;
      int         alu_err;
      int         ovl;
      int         unst;
      int         idle_bad;
   } res_t;

   typedef struct {
      logic [7:0] opc;
      logic [7:0] opnd;
      int         drd, dwr, lat, kind;
      logic [7:0] val;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: what one opcode must do, from operand value and ack delays.
   function automatic res_t model(input logic [7:0] opc, input logic [7:0] opnd,
                                  input int drd, input int dwr);
      res_t m;
      logic [1:0] op;
      logic [2:0] b;
      logic [7:0] res;
      bit         is_mem;
      m = '{default: 0};
      op = opc[7:6];
      b = opc[5:3];
      is_mem = (opc[2:0] == 3'd6);
      if (op == 2'b00) begin
         m.lat = 1;
         m.ill = 1;
         return m;
      end
      res = (op == 2'b10) ? (opnd & ~(8'h01 << b)) : (opnd | (8'h01 << b));
      m.alu_act = 1;
      m.rdcyc = is_mem ? drd + 1 : 0;
      if (op == 2'b01) begin
         m.flagwe = 1;
         m.fzv = !opnd[b];
         m.fhv = 1'b1;
         m.lat = is_mem ? 3 + drd : 2;
      end else if (is_mem) begin
         m.wrcyc = dwr + 1;
         m.mdata = res;
         m.lat = 4 + drd + dwr;
      end else begin
         m.regwe = 1;
         m.wsel = opc[2:0];
         m.wdata = res;
         m.lat = 2;
      end
      m.busycyc = m.lat - 1;
      return m;
   endfunction

   task automatic setup_env(input logic [7:0] opc, input logic [7:0] opnd, input int drd, input int dwr);
      for (int i = 0; i < 8; i++) regs[i] = opnd ^ 8'(i + 1);
      regs[opc[2:0]] = opnd;
      mem_hl = (opc[2:0] == 3'd6) ? opnd : ~opnd;
      drd_cur = drd;
      dwr_cur = dwr;
   endtask

   task automatic run(input logic [7:0] opc, input logic [7:0] opnd, input int drd,
                      input int dwr, input bit hold, output res_t o);
      o = '{default: 0};
      setup_env(opc, opnd, drd, dwr);
      @(negedge clk);
      bus.opcode = opc;
      bus.start = 1'b1;
      for (int c = 1; c <= 60 && o.lat == 0; c++) begin
         @(negedge clk);
         if (bus.busy) o.busycyc++;
         if (bus.reg_we) begin
            o.regwe++; o.wsel = bus.reg_wr_sel; o.wdata = bus.reg_wr_data;
         end
         if (bus.flag_we) begin
            o.flagwe++; o.fzv = bus.flag_z; o.fnv = bus.flag_n; o.fhv = bus.flag_h;
         end
         if (bus.mem_rd) o.rdcyc++;
         if (bus.mem_wr) begin
            o.wrcyc++;
            if (o.wrcyc == 1) o.mdata = bus.mem_wdata;
            else if (bus.mem_wdata != o.mdata) o.unst++;
         end
         if (bus.mem_rd && bus.mem_wr) o.ovl++;
         if (bus.alu_fn != 2'b00) begin
            o.alu_act++;
            if (bus.alu_a != opnd || bus.alu_b != opc[5:3] || bus.alu_fn != opc[7:6]) o.alu_err++;
         end else if (bus.alu_a != 8'h00 || bus.alu_b != 3'd0) o.alu_err++;
         if (bus.done) begin
            o.lat = c;
            o.ill = bus.illegal;
         end
         // a start while busy or in the done cycle must be ignored
         bus.start = hold;
         bus.opcode = 8'($urandom);
      end
      @(negedge clk);
      if (bus.busy || bus.done || bus.illegal) o.idle_bad++;
      bus.start = 1'b0;
   endtask

   task automatic check_all(input string t, input res_t o, input res_t e);
      chk({t, ".lat"}, o.lat, e.lat);
      chk({t, ".illegal"}, o.ill, e.ill);
      chk({t, ".reg_we_cycles"}, o.regwe, e.regwe);
      chk({t, ".reg_wr_sel"}, o.wsel, e.wsel);
      chk({t, ".reg_wr_data"}, o.wdata, e.wdata);
      chk({t, ".flag_we_cycles"}, o.flagwe, e.flagwe);
      chk({t, ".flag_z"}, o.fzv, e.fzv);
      chk({t, ".flag_n"}, o.fnv, e.fnv);
      chk({t, ".flag_h"}, o.fhv, e.fhv);
      chk({t, ".mem_rd_cycles"}, o.rdcyc, e.rdcyc);
      chk({t, ".mem_wr_cycles"}, o.wrcyc, e.wrcyc);
      chk({t, ".mem_wdata"}, o.mdata, e.mdata);
      chk({t, ".busy_cycles"}, o.busycyc, e.busycyc);
      chk({t, ".alu_cycles"}, o.alu_act, e.alu_act);
      chk({t, ".alu_bad"}, o.alu_err, 0);
      chk({t, ".rd_wr_overlap"}, o.ovl, 0);
      chk({t, ".wdata_unstable"}, o.unst, 0);
      chk({t, ".idle_after_done"}, o.idle_bad, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[10];
      res_t o, e;
      bit   seen;
      int   bad;
      logic [7:0] ropc, ropnd;
      int   rdrd, rdwr;

      // kind: 0 illegal, 1 BIT (val[0] = Z), 2 register write, 3 (HL) write
      vt[0] = '{8'h47, 8'h01, 0, 0, 2, 1, 8'h00};
      vt[1] = '{8'hBF, 8'hA5, 0, 0, 2, 2, 8'h25};
      vt[2] = '{8'hC0, 8'hFE, 0, 0, 2, 2, 8'hFF};
      vt[3] = '{8'h66, 8'hEF, 3, 0, 6, 1, 8'h01};
      vt[4] = '{8'hDE, 8'hF7, 0, 0, 4, 3, 8'hFF};
      vt[5] = '{8'h86, 8'h5A, 0, 0, 4, 3, 8'h5A};
      vt[6] = '{8'h07, 8'h00, 0, 0, 1, 0, 8'h00};
      vt[7] = '{8'h7E, 8'h80, 1, 0, 4, 1, 8'h00};
      vt[8] = '{8'hFE, 8'h00, 2, 3, 9, 3, 8'h80};
      vt[9] = '{8'h3F, 8'h55, 0, 0, 1, 0, 8'h00};

      bus.start = 1'b0;
      bus.opcode = 8'h00;
      noise_en = 1'b0;
      drd_cur = 0;
      dwr_cur = 0;
      mem_hl = 8'h00;
      for (int i = 0; i < 8; i++) regs[i] = 8'(i);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs_during", {bus.busy, bus.done, bus.illegal, bus.reg_we, bus.flag_we,
          bus.mem_rd, bus.mem_wr, bus.alu_fn, bus.alu_b, bus.alu_a}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs_after", {bus.busy, bus.done, bus.illegal, bus.reg_we, bus.flag_we,
          bus.mem_rd, bus.mem_wr, bus.alu_fn, bus.alu_a, bus.mem_wdata, bus.reg_wr_data}, 0);

      for (int i = 0; i < 10; i++) begin
         e = '{default: 0};
         e.lat = vt[i].lat;
         if (vt[i].kind == 0) e.ill = 1;
         else begin
            e.alu_act = 1;
            e.busycyc = vt[i].lat - 1;
            e.rdcyc = (vt[i].opc[2:0] == 3'd6) ? vt[i].drd + 1 : 0;
         end
         if (vt[i].kind == 1) begin e.flagwe = 1; e.fzv = vt[i].val[0]; e.fhv = 1'b1; end
         if (vt[i].kind == 2) begin e.regwe = 1; e.wsel = vt[i].opc[2:0]; e.wdata = vt[i].val; end
         if (vt[i].kind == 3) begin e.wrcyc = vt[i].dwr + 1; e.mdata = vt[i].val; end
         noise_en = (i % 3 == 1);
         run(vt[i].opc, vt[i].opnd, vt[i].drd, vt[i].dwr, bit'(i % 2), o);
         check_all($sformatf("vec%0d_%02h", i, vt[i].opc), o, e);
      end

      // reset while waiting in MWR: abort with no done and no lingering strobes
      noise_en = 1'b0;
      setup_env(8'hFE, 8'h00, 0, 10);
      @(negedge clk);
      bus.opcode = 8'hFE;
      bus.start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.mem_wr) seen = 1'b1;
      end
      chk("rst_mwr_reached", seen, 1);
      reset = 1'b1;
      #1;
      chk("rst_cycle_strobes", {bus.mem_wr, bus.done, bus.reg_we, bus.flag_we}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_next_cycle", {bus.mem_wr, bus.busy, bus.done}, 0);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy || bus.done || bus.mem_wr || bus.mem_rd) bad++;
      end
      chk("rst_quiet", bad, 0);
      run(8'h47, 8'h01, 0, 0, 1'b0, o);
      check_all("post_rst_47", o, model(8'h47, 8'h01, 0, 0));

      for (int k = 0; k < 60; k++) begin
         ropc = 8'($urandom);
         ropnd = 8'($urandom);
         rdrd = $urandom_range(0, 3);
         rdwr = $urandom_range(0, 3);
         noise_en = bit'($urandom_range(0, 1));
         run(ropc, ropnd, rdrd, rdwr, bit'($urandom_range(0, 1)), o);
         check_all($sformatf("rnd%0d_%02h", k, ropc), o, model(ropc, ropnd, rdrd, rdwr));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
